// File: rtl/ram_fill_check_ctrl.sv
// ram_fill_check_ctrl: fills a RAM window with a deterministic pattern, reads it
// back, compares each word and reports pass/fail, error count and first bad address.
module ram_fill_check_ctrl #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_re,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [AW:0]   i_count,
    input  logic [DW-1:0] i_seed,
    input  logic          i_mode,
    output logic          o_mem_e,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_din,
    output logic          o_mem_w,
    output logic          o_mem_r,
    input  logic [DW-1:0] i_mem_dout,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic [15:0]   o_err_count,
    output logic [AW-1:0] o_first_err_addr
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CMP, S_DONE} state_t;

    localparam logic [AW:0] K_ONE = 1;

    state_t        r_state, w_next;
    logic [AW-1:0] r_base;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_seed;
    logic          r_mode;
    logic [AW:0]   r_k;
    logic [15:0]   r_err;
    logic          r_pass;
    logic [AW-1:0] r_first;

    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_kx;
    logic [DW-1:0] w_pat;
    logic          w_last;
    logic          w_mis;

    // Window address wraps naturally by truncating to AW bits.
    assign w_addr = r_base + r_k[AW-1:0];
    assign w_kx   = DW'(r_k);
    assign w_pat  = r_mode ? (r_k[0] ? ~r_seed : r_seed) : (r_seed + w_kx);
    // Only meaningful in WRITE/READ/CMP, where N is known to be non-zero.
    assign w_last = (r_k == (r_count - K_ONE));
    assign w_mis  = (i_mem_dout != w_pat);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_re) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_count == '0) ? S_DONE : S_WRITE;
            S_WRITE: if (w_last) w_next = S_READ;
            S_READ:  w_next = S_CMP;
            S_CMP:   w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Run parameters, offset counter and result registers.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_base  <= '0;
            r_count <= '0;
            r_seed  <= '0;
            r_mode  <= 1'b0;
            r_k     <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
            r_first <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base  <= i_base;
                        r_count <= i_count;
                        r_seed  <= i_seed;
                        r_mode  <= i_mode;
                        r_k     <= '0;
                        r_err   <= '0;
                        r_first <= '0;
                        // An empty window trivially passes; pass is visible with done.
                        r_pass  <= (i_count == '0);
                    end
                end
                S_WRITE: r_k <= w_last ? '0 : (r_k + K_ONE);
                S_CMP: begin
                    if (w_mis) begin
                        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                        if (r_err == '0)       r_first <= w_addr;
                    end
                    if (w_last) r_pass <= (r_err == '0) && !w_mis;
                    else        r_k    <= r_k + K_ONE;
                end
                default: ;
            endcase
        end
    end

    // Memory port and status outputs decoded from the current state.
    always_comb begin
        o_mem_e    = 1'b0;
        o_mem_w    = 1'b0;
        o_mem_r    = 1'b0;
        o_mem_addr = '0;
        o_mem_din  = '0;
        o_done     = 1'b0;
        o_busy     = (r_state != S_IDLE);
        case (r_state)
            S_WRITE: begin
                o_mem_e    = 1'b1;
                o_mem_w    = 1'b1;
                o_mem_addr = w_addr;
                o_mem_din  = w_pat;
            end
            S_READ, S_CMP: begin
                o_mem_e    = 1'b1;
                o_mem_r    = 1'b1;
                o_mem_addr = w_addr;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_pass           = r_pass;
    assign o_err_count      = r_err;
    assign o_first_err_addr = r_first;

endmodule
